div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 33 +++
 rtl/div_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_div_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared ALU package: operation encoding, divider idle opcode and the
// divider-controller state type, plus small op-classification helpers.
package div_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  // Opcode presented to the divider whenever no division is being launched.
  localparam alu_op_t DIV_IDLE_OP = ALU_NOP;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    DONE,
    DRAIN
  } div_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_rem_op(input alu_op_t op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_op(input alu_op_t op);
    return op inside {ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencing controller for the execute stage. Launches the external
// multi-cycle divider, stalls the pipeline until its result is captured,
// short-circuits divide-by-zero and signed overflow, and drains an aborted
// division before the divider may be restarted.
// Optional feature: define DIV_RESULT_CACHE_EN to keep the last completed
// operand pair and its quotient/remainder so a repeat op finishes in one cycle.
//
// state | meaning
// IDLE  | waiting for a divide op from execute
// START | one-cycle launch strobe to the divider
// BUSY  | divider running, counter tracks cycles since launch
// DONE  | result register valid, one-cycle result_valid pulse
// DRAIN | op was flushed, let the divider finish before reuse
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  alu_op_t     alu_op,
  input  logic [31:0] left_operand,
  input  logic [31:0] right_operand,
  input  logic        flush,
  output alu_op_t     div_alu_op,
  output logic [31:0] div_left,
  output logic [31:0] div_right,
  input  logic [31:0] div_res_unsigned,
  input  logic [31:0] rem_res_unsigned,
  input  logic [31:0] div_res_signed,
  input  logic [31:0] rem_res_signed,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid
);

  localparam int CW = $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t    state;
  logic [CW-1:0] cnt;
  alu_op_t       op_q;

  logic          div_req;
  logic          accept;
  logic          div_by_zero;
  logic          signed_ovf;
  logic          cache_hit;
  logic [31:0]   sel_res;

`ifdef DIV_RESULT_CACHE_EN
  logic          c_valid;
  logic          c_signed;
  logic [31:0]   c_left;
  logic [31:0]   c_right;
  logic [31:0]   c_quot;
  logic [31:0]   c_rem;

  assign cache_hit = c_valid && (left_operand == c_left) && (right_operand == c_right)
                     && (is_signed_op(alu_op) == c_signed);
`else
  assign cache_hit = 1'b0;
`endif

  assign div_req     = in_valid && is_div_op(alu_op);
  assign accept      = (state == IDLE) && div_req && !flush;
  assign div_by_zero = (right_operand == 32'h0);
  assign signed_ovf  = is_signed_op(alu_op) && (left_operand == 32'h8000_0000)
                       && (right_operand == 32'hFFFF_FFFF);

  // Pipeline stall: held from the accept cycle until DONE; a flush releases it at once.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:        stall = accept;
        START, BUSY: stall = !flush;
        DRAIN:       stall = div_req;
        default:     stall = 1'b0;
      endcase
    end
  end

  // Pick the divider output matching the latched op.
  always_comb begin
    sel_res = div_res_unsigned;
    unique case (op_q)
      ALU_DIV:  sel_res = div_res_signed;
      ALU_DIVU: sel_res = div_res_unsigned;
      ALU_REM:  sel_res = rem_res_signed;
      ALU_REMU: sel_res = rem_res_unsigned;
      default:  sel_res = div_res_unsigned;
    endcase
  end

  // Sequencing FSM with registered divider controls, result and valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= DIV_IDLE_OP;
      div_alu_op   <= DIV_IDLE_OP;
      div_left     <= '0;
      div_right    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      c_valid      <= 1'b0;
      c_signed     <= 1'b0;
      c_left       <= '0;
      c_right      <= '0;
      c_quot       <= '0;
      c_rem        <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      div_alu_op   <= DIV_IDLE_OP;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= alu_op;
            div_left  <= left_operand;
            div_right <= right_operand;
            if (div_by_zero) begin
              result       <= is_rem_op(alu_op) ? left_operand : 32'hFFFF_FFFF;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (signed_ovf) begin
              result       <= is_rem_op(alu_op) ? 32'h0 : 32'h8000_0000;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (cache_hit) begin
`ifdef DIV_RESULT_CACHE_EN
              result       <= is_rem_op(alu_op) ? c_rem : c_quot;
`endif
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              div_alu_op <= alu_op;
              state      <= START;
            end
          end
        end
        START: begin
          cnt   <= CNT_ONE;
          state <= flush ? DRAIN : BUSY;
        end
        BUSY: begin
          if (flush) begin
            // A flush on the final cycle leaves nothing to drain.
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= DRAIN;
            end
          end else if (cnt == CNT_LAST) begin
            result       <= sel_res;
            result_valid <= 1'b1;
            cnt          <= '0;
            state        <= DONE;
`ifdef DIV_RESULT_CACHE_EN
            c_valid  <= 1'b1;
            c_signed <= is_signed_op(op_q);
            c_left   <= div_left;
            c_right  <= div_right;
            c_quot   <= is_signed_op(op_q) ? div_res_signed : div_res_unsigned;
            c_rem    <= is_signed_op(op_q) ? rem_res_signed : rem_res_unsigned;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
`ifdef DIV_RESULT_CACHE_EN
      if (flush) c_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural multi-cycle divider and
// a result scoreboard. Honours DIV_RESULT_CACHE_EN for cache-dependent checks.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int DIV_LATENCY = 32;
  localparam int FULL_LAT    = DIV_LATENCY + 2;
`ifdef DIV_RESULT_CACHE_EN
  localparam int CACHE_LAT    = 1;
  localparam int CACHE_STARTS = 1;
`else
  localparam int CACHE_LAT    = FULL_LAT;
  localparam int CACHE_STARTS = 2;
`endif

  logic        clk, rst, in_valid, flush;
  alu_op_t     alu_op, div_alu_op;
  logic [31:0] left_operand, right_operand, div_left, div_right;
  logic [31:0] div_res_unsigned, rem_res_unsigned, div_res_signed, rem_res_signed;
  logic        stall, result_valid;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int starts = 0;
  int overlap = 0;

  logic [31:0] sb_val[$];
  int          sb_lat[$];
  int          sb_t0[$];

  div_ctrl #(.DIV_LATENCY(DIV_LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
    .left_operand(left_operand), .right_operand(right_operand), .flush(flush),
    .div_alu_op(div_alu_op), .div_left(div_left), .div_right(div_right),
    .div_res_unsigned(div_res_unsigned), .rem_res_unsigned(rem_res_unsigned),
    .div_res_signed(div_res_signed), .rem_res_signed(rem_res_signed),
    .stall(stall), .result(result), .result_valid(result_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: latches operands on a launch, outputs are garbage
  // until DIV_LATENCY cycles have elapsed.
  logic [31:0] m_l, m_r;
  int          m_cnt;
  bit          m_active;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 0;
      m_cnt    <= 0;
    end else if (div_alu_op != DIV_IDLE_OP) begin
      if (m_active && m_cnt < DIV_LATENCY) overlap <= overlap + 1;
      m_l      <= div_left;
      m_r      <= div_right;
      m_cnt    <= 1;
      m_active <= 1;
    end else if (m_active && m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
    end
  end

  always_comb begin
    div_res_unsigned = 32'hDEAD_BEEF;
    rem_res_unsigned = 32'hDEAD_BEEF;
    div_res_signed   = 32'hDEAD_BEEF;
    rem_res_signed   = 32'hDEAD_BEEF;
    if (m_active && m_cnt >= DIV_LATENCY) begin
      if (m_r == 32'h0) begin
        div_res_unsigned = 32'hFFFF_FFFF; rem_res_unsigned = m_l;
        div_res_signed   = 32'hFFFF_FFFF; rem_res_signed   = m_l;
      end else begin
        div_res_unsigned = m_l / m_r;
        rem_res_unsigned = m_l % m_r;
        if (m_l == 32'h8000_0000 && m_r == 32'hFFFF_FFFF) begin
          div_res_signed = m_l; rem_res_signed = 32'h0;
        end else begin
          div_res_signed = $signed(m_l) / $signed(m_r);
          rem_res_signed = $signed(m_l) % $signed(m_r);
        end
      end
    end
  end

  always @(negedge clk) if (!rst && div_alu_op != DIV_IDLE_OP) starts++;

  // Scoreboard: every result_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      checks++;
      if (sb_val.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: result_valid with result=%h, no op outstanding", result);
      end else begin
        automatic logic [31:0] ev = sb_val.pop_front();
        automatic int el = sb_lat.pop_front();
        automatic int et = sb_t0.pop_front();
        if (result !== ev) begin
          errors++;
          $display("FAIL result_value: got %h expected %h", result, ev);
        end
        if (el >= 0) begin
          checks++;
          if ((cyc - et) !== el) begin
            errors++;
            $display("FAIL result_latency: got %0d cycles expected %0d", cyc - et, el);
          end
        end
      end
    end
  end

  // Wait, from just after a negedge, until stall drops (the DONE cycle).
  task automatic wait_done(input string name);
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (!stall) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL %s_timeout: stall still %b after 200 cycles, expected 0", name, stall);
    end
  endtask

  task automatic push_exp(input logic [31:0] v, input int lat);
    sb_val.push_back(v);
    sb_lat.push_back(lat);
    sb_t0.push_back(cyc);
  endtask

  task automatic issue(input alu_op_t op, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] exp, input int lat, input bit fl_done);
    @(negedge clk);
    in_valid = 1; alu_op = op; left_operand = l; right_operand = r; flush = 0;
    push_exp(exp, lat);
    wait_done(op.name());
    in_valid = 0;
    if (fl_done) begin
      flush = 1;
      #1;
      checks++;
      if (result_valid !== 1'b1) begin
        errors++;
        $display("FAIL flush_in_done: result_valid=%b expected 1", result_valid);
      end
      @(negedge clk);
      flush = 0;
    end
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; flush = 0; alu_op = ALU_NOP;
    left_operand = 0; right_operand = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checks += 6;
    if (stall !== 1'b0)             begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    if (result_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    if (result !== 32'h0)           begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    if (div_alu_op !== DIV_IDLE_OP) begin errors++; $display("FAIL reset_div_op: got %0d expected %0d", div_alu_op, DIV_IDLE_OP); end
    if (div_left !== 32'h0)         begin errors++; $display("FAIL reset_div_left: got %h expected 0", div_left); end
    if (div_right !== 32'h0)        begin errors++; $display("FAIL reset_div_right: got %h expected 0", div_right); end
  endtask

  task automatic test_unsigned;
    int s0 = starts;
    issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 0);
    issue(ALU_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT, 0);
    checks++;
    if (starts - s0 !== 2) begin errors++; $display("FAIL unsigned_starts: got %0d expected 2", starts - s0); end
  endtask

  task automatic test_signed;
    issue(ALU_DIV, -32'sd20, 32'd3, 32'hFFFF_FFFA, FULL_LAT, 0);
    issue(ALU_REM, -32'sd20, 32'd3, 32'hFFFF_FFFE, FULL_LAT, 0);
  endtask

  task automatic test_div_zero;
    int s0 = starts;
    issue(ALU_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    issue(ALU_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    issue(ALU_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    checks++;
    if (starts - s0 !== 0) begin errors++; $display("FAIL divzero_starts: got %0d expected 0", starts - s0); end
  endtask

  task automatic test_overflow;
    int s0 = starts;
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    checks++;
    if (starts - s0 !== 0) begin errors++; $display("FAIL overflow_starts: got %0d expected 0", starts - s0); end
  endtask

  task automatic test_ignore;
    int s0 = starts;
    @(negedge clk);
    in_valid = 1; alu_op = ALU_ADD; left_operand = 10; right_operand = 2;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ignore_nondiv_stall: got %b expected 0", stall); end
    @(negedge clk);
    alu_op = ALU_DIV; flush = 1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b expected 0", stall); end
    @(negedge clk);
    in_valid = 0; flush = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (starts - s0 !== 0) begin errors++; $display("FAIL ignore_starts: got %0d expected 0", starts - s0); end
  endtask

  task automatic test_flush_done;
    issue(ALU_DIVU, 32'd99, 32'd9, 32'd11, FULL_LAT, 1);
  endtask

  task automatic test_done_present;
    issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 0);
    // still in the DONE cycle: present the next op now, it must wait for IDLE
    in_valid = 1; alu_op = ALU_REMU; left_operand = 100; right_operand = 7;
    push_exp(32'd2, FULL_LAT + 1);
    @(negedge clk);
    wait_done("done_present");
    in_valid = 0;
  endtask

  task automatic test_flush_drain;
    @(negedge clk);
    in_valid = 1; alu_op = ALU_DIVU; left_operand = 1000; right_operand = 9;
    repeat (11) @(negedge clk);
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b expected 1", stall); end
    in_valid = 0; flush = 1;
    #1; checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    @(negedge clk);
    flush = 0; in_valid = 1; alu_op = ALU_DIVU; left_operand = 200; right_operand = 9;
    push_exp(32'd22, 56);
    #1; checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b expected 1", stall); end
    @(negedge clk);
    wait_done("flush_drain");
    in_valid = 0;
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    in_valid = 1; alu_op = ALU_DIVU; left_operand = 50; right_operand = 5;
    repeat (6) @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    rst = 0;
    #1; checks += 2;
    if (stall !== 1'b0)   begin errors++; $display("FAIL rst_busy_stall: got %b expected 0", stall); end
    if (result !== 32'h0) begin errors++; $display("FAIL rst_busy_result: got %h expected 0", result); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_cache;
    int s0 = starts;
    issue(ALU_DIV, 32'd77, 32'd5, 32'd15, FULL_LAT, 0);
    issue(ALU_REM, 32'd77, 32'd5, 32'd2, CACHE_LAT, 0);
    checks++;
    if (starts - s0 !== CACHE_STARTS) begin
      errors++; $display("FAIL cache_starts: got %0d expected %0d", starts - s0, CACHE_STARTS);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore();
    test_flush_done();
    test_done_present();
    test_flush_drain();
    test_reset_busy();
    test_cache();
    repeat (5) @(negedge clk);
    checks += 2;
    if (sb_val.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: %0d results outstanding, expected 0", sb_val.size()); end
    if (overlap !== 0)       begin errors++; $display("FAIL divider_overlap: %0d restarts while busy, expected 0", overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
